// File: rtl/mel_pkg.sv
// mel_pkg: constants and types shared across the mel filter-bank blocks.
//   MEL_N_MEL / MEL_N_BIN / MEL_ACC_WIDTH : frame geometry and MAC accumulator
//   width, shared by the MAC sequencer, the MEL_MAC instance and the weight-ROM
//   generator so the three always agree.
//   mac_ctrl_state_t : state encoding of the mel_mac_ctrl sequencer.
package mel_pkg;

  localparam int MEL_N_MEL     = 40;
  localparam int MEL_N_BIN     = 257;
  localparam int MEL_ACC_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DESC,
    S_LOAD,
    S_RUN,
    S_DRAIN1,
    S_DRAIN2,
    S_OUT
  } mac_ctrl_state_t;

endpackage

// File: rtl/mel_mac_ctrl.sv
// mel_mac_ctrl: sequencer for the shared MEL_MAC of the mel filter bank.
// For every triangular filter it fetches a (start bin, length) descriptor,
// streams the matching spectrum bins and packed weights into the MAC, and
// hands the finished accumulation downstream on a valid/ready port.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle frame start (ignored unless idle)
//   busy, done          frame in progress / one-cycle end-of-frame pulse
//   desc_err            sticky: some descriptor started beyond the last bin
//   desc_addr           descriptor ROM address; desc_start/desc_len return
//                       one cycle later
//   spec_addr           spectrum buffer address (1-cycle read latency)
//   weight_addr         weight ROM address (1-cycle read latency)
//   mac_clear, mac_en   MEL_MAC controls, aligned with the memory read data
//   mac_c               MEL_MAC accumulator
//   out_valid/out_ready filter result handshake
//   out_idx, out_data   filter index and captured accumulator
module mel_mac_ctrl
  import mel_pkg::*;
#(
  parameter int N_MEL     = MEL_N_MEL,
  parameter int N_BIN     = MEL_N_BIN,
  parameter int ADDR_W    = 9,
  parameter int WADDR_W   = 12,
  parameter int ACC_WIDTH = MEL_ACC_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        desc_err,
  output logic [$clog2(N_MEL)-1:0]    desc_addr,
  input  logic [ADDR_W-1:0]           desc_start,
  input  logic [ADDR_W-1:0]           desc_len,
  output logic [ADDR_W-1:0]           spec_addr,
  output logic [WADDR_W-1:0]          weight_addr,
  output logic                        mac_clear,
  output logic                        mac_en,
  input  logic signed [ACC_WIDTH-1:0] mac_c,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(N_MEL)-1:0]    out_idx,
  output logic signed [ACC_WIDTH-1:0] out_data
);

  localparam int IDX_W = $clog2(N_MEL);
  // One extra bit so N_BIN - start and the start >= N_BIN test never wrap.
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MEL - 1);

  // Number of bins actually issued: the descriptor length clipped to the
  // spectrum end, zero when the start bin itself is out of range.
  function automatic logic [ADDR_W-1:0] clamp_len(input logic [ADDR_W-1:0] s,
                                                  input logic [ADDR_W-1:0] l);
    logic [LEN_W-1:0] room;
    room = LEN_W'(N_BIN) - {1'b0, s};
    if ({1'b0, s} >= LEN_W'(N_BIN))
      return '0;
    else if ({1'b0, l} < room)
      return l;
    else
      return room[ADDR_W-1:0];
  endfunction

  mac_ctrl_state_t    state;
  logic [IDX_W-1:0]   idx;
  logic [WADDR_W-1:0] wptr;
  logic [ADDR_W-1:0]  j;
  logic [ADDR_W-1:0]  eff_len;
  logic               mac_clr_r;

  logic [ADDR_W-1:0]  eff_len_c;
  logic               desc_bad_c;
  logic               zero_len_c;

  assign eff_len_c  = clamp_len(desc_start, desc_len);
  assign desc_bad_c = ({1'b0, desc_start} >= LEN_W'(N_BIN));
  assign zero_len_c = (eff_len_c == '0);

  assign desc_addr = idx;
  // An empty filter still has to flush the previous accumulation; the clear
  // goes out in LOAD itself since the descriptor is only known then.
  assign mac_clear = mac_clr_r | ((state == S_LOAD) && zero_len_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      wptr        <= '0;
      j           <= '0;
      eff_len     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      desc_err    <= 1'b0;
      spec_addr   <= '0;
      weight_addr <= '0;
      mac_en      <= 1'b0;
      mac_clr_r   <= 1'b0;
      out_valid   <= 1'b0;
      out_idx     <= '0;
      out_data    <= '0;
    end else begin
      done      <= 1'b0;
      mac_en    <= 1'b0;
      mac_clr_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_DESC;
            idx      <= '0;
            wptr     <= '0;
            desc_err <= 1'b0;
            busy     <= 1'b1;
          end
        end
        // descriptor read in flight
        S_DESC: state <= S_LOAD;
        // descriptor available: set up the bin and weight streams
        S_LOAD: begin
          spec_addr   <= desc_start;
          weight_addr <= wptr;
          // weights are packed by full descriptor length, clipped or not
          wptr        <= wptr + WADDR_W'(desc_len);
          eff_len     <= eff_len_c;
          j           <= '0;
          if (desc_bad_c)
            desc_err <= 1'b1;
          state <= zero_len_c ? S_DRAIN1 : S_RUN;
        end
        // one bin per cycle; MAC controls trail by the memory latency
        S_RUN: begin
          mac_en    <= 1'b1;
          mac_clr_r <= (j == '0);
          if (j == eff_len - ADDR_W'(1)) begin
            state <= S_DRAIN1;
          end else begin
            j           <= j + ADDR_W'(1);
            spec_addr   <= spec_addr + ADDR_W'(1);
            weight_addr <= weight_addr + WADDR_W'(1);
          end
        end
        // last product entering the MAC
        S_DRAIN1: state <= S_DRAIN2;
        // accumulator final: capture it
        S_DRAIN2: begin
          out_data  <= mac_c;
          out_idx   <= idx;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        // result held until accepted
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= S_DESC;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mel_mac_ctrl.sv
// Directed bench for mel_mac_ctrl with N_MEL=3: models the descriptor ROM,
// spectrum buffer and weight ROM (1-cycle reads) and a MEL_MAC
// (en: c <= (clear ? 0 : c) + s*w; clear alone: c <= 0).
module tb_mel_mac_ctrl;

  localparam int N_MEL   = 3;
  localparam int N_BIN   = 257;
  localparam int ADDR_W  = 9;
  localparam int WADDR_W = 12;
  localparam int ACC_W   = 32;

  logic               clk = 1'b0;
  logic               rst, start, out_ready;
  logic               busy, done, desc_err, mac_clear, mac_en, out_valid;
  logic [1:0]         desc_addr, out_idx;
  logic [ADDR_W-1:0]  desc_start, desc_len, spec_addr;
  logic [WADDR_W-1:0] weight_addr;
  logic signed [ACC_W-1:0] mac_c, out_data;

  logic [ADDR_W-1:0]  d_start [0:3];
  logic [ADDR_W-1:0]  d_len   [0:3];
  logic signed [15:0] spec_mem   [0:511];
  logic signed [15:0] weight_mem [0:4095];
  logic signed [15:0] spec_q, weight_q;
  logic signed [31:0] prod;

  int tests = 0;
  int fails = 0;
  int n;
  int spec_log[$];
  int wt_log[$];
  int prev_spec, prev_wt;
  int clr_alone = 0;
  int ov_cycles = 0;
  int done_cnt  = 0;
  int stall_issues;
  logic [ADDR_W-1:0] held_spec;

  int exp_spec_a[11] = '{0, 1, 2, 3, 2, 3, 4, 5, 4, 5, 6};
  int exp_spec_c[4]  = '{255, 256, 7, 8};
  int exp_wt_c[4]    = '{0, 1, 6, 7};

  always #5 clk = ~clk;

  mel_mac_ctrl #(
    .N_MEL(N_MEL), .N_BIN(N_BIN), .ADDR_W(ADDR_W),
    .WADDR_W(WADDR_W), .ACC_WIDTH(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .desc_err(desc_err), .desc_addr(desc_addr), .desc_start(desc_start),
    .desc_len(desc_len), .spec_addr(spec_addr), .weight_addr(weight_addr),
    .mac_clear(mac_clear), .mac_en(mac_en), .mac_c(mac_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data)
  );

  // memory and MAC models
  assign prod = 32'(spec_q) * 32'(weight_q);

  always_ff @(posedge clk) begin
    desc_start <= d_start[desc_addr];
    desc_len   <= d_len[desc_addr];
    spec_q     <= spec_mem[spec_addr];
    weight_q   <= weight_mem[weight_addr];
    if (mac_en)
      mac_c <= (mac_clear ? 32'sd0 : mac_c) + prod;
    else if (mac_clear)
      mac_c <= 32'sd0;
  end

  // issue log: an mac_en cycle corresponds to the addresses of the cycle before
  always @(negedge clk) begin
    if (mac_en) begin
      spec_log.push_back(prev_spec);
      wt_log.push_back(prev_wt);
    end
    if (mac_clear && !mac_en) clr_alone++;
    if (out_valid) ov_cycles++;
    if (done) done_cnt++;
    prev_spec = int'(spec_addr);
    prev_wt   = int'(weight_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 100);
    if (!out_valid) chk("valid_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 512; i++)  spec_mem[i]   = 16'sh4000;
    for (int i = 0; i < 4096; i++) weight_mem[i] = 16'sh4000;
    d_start[0] = 9'd0; d_len[0] = 9'd4;
    d_start[1] = 9'd2; d_len[1] = 9'd4;
    d_start[2] = 9'd4; d_len[2] = 9'd3;
    d_start[3] = 9'd0; d_len[3] = 9'd0;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {58'd0, busy, done, desc_err, out_valid, mac_en, mac_clear}, 64'd0);
    chk("reset_data", {30'd0, out_idx, out_data}, 64'd0);
    chk("reset_addr", {41'd0, desc_addr, spec_addr, weight_addr}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // frame A: uniform 0.5 x 0.5 products, out_ready high
    spec_log.delete(); wt_log.delete();
    pulse_start();
    chk("a_busy", {63'd0, busy}, 64'd1);
    wait_valid(n);
    chk("a_f0_lat", n, 8);
    chk("a_f0_out", {30'd0, out_idx, out_data}, {30'd0, 2'd0, 32'h4000_0000});
    wait_valid(n);
    chk("a_f1_lat", n, 9);
    chk("a_f1_out", {30'd0, out_idx, out_data}, {30'd0, 2'd1, 32'h4000_0000});
    wait_valid(n);
    chk("a_f2_lat", n, 8);
    chk("a_f2_out", {30'd0, out_idx, out_data}, {30'd0, 2'd2, 32'h3000_0000});
    @(negedge clk);
    chk("a_done", {62'd0, done, busy}, 64'b10);
    @(negedge clk);
    chk("a_done_pulse", {63'd0, done}, 64'd0);
    chk("a_issue_cnt", wt_log.size(), 11);
    for (int i = 0; i < 11 && i < wt_log.size(); i++) begin
      chk($sformatf("a_waddr%0d", i), wt_log[i], i);
      chk($sformatf("a_saddr%0d", i), spec_log[i], exp_spec_a[i]);
    end

    // frame B: backpressure at filter 1
    pulse_start();
    wait_valid(n);
    chk("b_f0_out", {30'd0, out_idx, out_data}, {30'd0, 2'd0, 32'h4000_0000});
    @(negedge clk);
    out_ready = 1'b0;
    wait_valid(n);
    chk("b_f1_lat", n, 8);
    stall_issues = spec_log.size();
    held_spec = spec_addr;
    repeat (5) begin
      @(negedge clk);
      chk("b_stall_vld_en", {62'd0, out_valid, mac_en}, 64'b10);
      chk("b_stall_out", {30'd0, out_idx, out_data}, {30'd0, 2'd1, 32'h4000_0000});
      chk("b_stall_saddr", spec_addr, held_spec);
    end
    chk("b_stall_issues", spec_log.size(), stall_issues);
    out_ready = 1'b1;
    wait_valid(n);
    chk("b_f2_out", {30'd0, out_idx, out_data}, {30'd0, 2'd2, 32'h3000_0000});
    @(negedge clk);
    chk("b_done", {63'd0, done}, 64'd1);

    // frame C: clipped descriptor, out-of-range descriptor, wptr by full length
    for (int i = 0; i < 512; i++)  spec_mem[i]   = 16'(i);
    for (int i = 0; i < 4096; i++) weight_mem[i] = 16'(i + 1);
    d_start[0] = 9'd255; d_len[0] = 9'd4;
    d_start[1] = 9'd300; d_len[1] = 9'd2;
    d_start[2] = 9'd7;   d_len[2] = 9'd2;
    @(negedge clk);
    spec_log.delete(); wt_log.delete(); clr_alone = 0;
    pulse_start();
    wait_valid(n);
    chk("c_f0_lat", n, 6);
    chk("c_f0_out", {30'd0, out_idx, out_data}, {30'd0, 2'd0, 32'd767});
    chk("c_f0_err", {63'd0, desc_err}, 64'd0);
    wait_valid(n);
    chk("c_f1_lat", n, 5);
    chk("c_f1_out", {30'd0, out_idx, out_data}, {30'd0, 2'd1, 32'd0});
    chk("c_f1_err", {63'd0, desc_err}, 64'd1);
    chk("c_f1_clr_alone", clr_alone, 1);
    wait_valid(n);
    chk("c_f2_lat", n, 7);
    chk("c_f2_out", {30'd0, out_idx, out_data}, {30'd0, 2'd2, 32'd113});
    @(negedge clk);
    chk("c_done_err", {62'd0, done, desc_err}, 64'b11);
    chk("c_issue_cnt", wt_log.size(), 4);
    for (int i = 0; i < 4 && i < wt_log.size(); i++) begin
      chk($sformatf("c_saddr%0d", i), spec_log[i], exp_spec_c[i]);
      chk($sformatf("c_waddr%0d", i), wt_log[i], exp_wt_c[i]);
    end

    // frame D: zero-length first filter
    d_start[0] = 9'd10; d_len[0] = 9'd0;
    d_start[1] = 9'd0;  d_len[1] = 9'd4;
    d_start[2] = 9'd1;  d_len[2] = 9'd1;
    @(negedge clk);
    pulse_start();
    chk("d_err_cleared", {63'd0, desc_err}, 64'd0);
    @(negedge clk);
    chk("d_load_clear", {62'd0, mac_clear, mac_en}, 64'b10);
    wait_valid(n);
    chk("d_f0_lat", n, 3);
    chk("d_f0_out", {30'd0, out_idx, out_data}, {30'd0, 2'd0, 32'd0});
    wait_valid(n);
    chk("d_f1_lat", n, 9);
    chk("d_f1_out", {30'd0, out_idx, out_data}, {30'd0, 2'd1, 32'd20});
    wait_valid(n);
    chk("d_f2_lat", n, 6);
    chk("d_f2_out", {30'd0, out_idx, out_data}, {30'd0, 2'd2, 32'd5});
    @(negedge clk);
    chk("d_done", {63'd0, done}, 64'd1);

    // frame E: reset after two issues, then a clean frame with stray starts
    for (int i = 0; i < 512; i++) spec_mem[i] = 16'(i + 1);
    d_start[0] = 9'd0; d_len[0] = 9'd4;
    d_start[1] = 9'd4; d_len[1] = 9'd4;
    d_start[2] = 9'd8; d_len[2] = 9'd4;
    @(negedge clk);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("e_run_en", {63'd0, mac_en}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("e_rst_ctrl", {58'd0, busy, done, desc_err, out_valid, mac_en, mac_clear}, 64'd0);
    chk("e_rst_data", {30'd0, out_idx, out_data}, 64'd0);
    chk("e_rst_addr", {41'd0, desc_addr, spec_addr, weight_addr}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("e_idle", {62'd0, busy, mac_en}, 64'd0);
    ov_cycles = 0; done_cnt = 0;
    pulse_start();
    wait_valid(n);
    chk("e_f0_lat", n, 8);
    chk("e_f0_out", {30'd0, out_idx, out_data}, {30'd0, 2'd0, 32'd30});
    repeat (3) @(negedge clk);
    pulse_start();
    wait_valid(n);
    chk("e_f1_out", {30'd0, out_idx, out_data}, {30'd0, 2'd1, 32'd174});
    pulse_start();
    wait_valid(n);
    chk("e_f2_out", {30'd0, out_idx, out_data}, {30'd0, 2'd2, 32'd446});
    repeat (15) @(negedge clk);
    chk("e_out_count", ov_cycles, 3);
    chk("e_done_count", done_cnt, 1);
    chk("e_idle_end", {63'd0, busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
